multicycle_alu: RTL and testbench

- Execution unit that consumes the 4-bit ALU operation code produced by the ALU control decoder.
- Adds a start/busy/done handshake so that iterative operations can take more than one cycle.
- Executes single-cycle ops (ADD, SUB, OR, LUI) in 1 cycle and an iterative 32-bit unsigned multiply in 32 cycles.
- Sits in the EX stage; the main control stalls the pipeline while busy_o is high.

---
 rtl/alu_ops_pkg.sv | 19 +
 rtl/multicycle_alu_shift_add_multiplier.sv | 44 ++++
 rtl/multicycle_alu.sv | 157 +++++++++++++++
 tb/tb_multicycle_alu.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_ops_pkg.sv
// Shared ALU op codes and execution-FSM state encoding.
// MULTICYCLE_ALU_DIV_EN adds the DIV state.
package alu_ops_pkg;

  localparam logic [3:0] ALU_ADD         = 4'b0011;
  localparam logic [3:0] ALU_SUB         = 4'b0100;
  localparam logic [3:0] ALU_OR          = 4'b0010;
  localparam logic [3:0] ALU_LUI         = 4'b0101;
  localparam logic [3:0] ALU_MULTU       = 4'b0110;
  localparam logic [3:0] ALU_DIVU        = 4'b0111;
  localparam logic [3:0] ALU_NOP_DEFAULT = 4'b1001;

`ifdef MULTICYCLE_ALU_DIV_EN
  typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE, ST_DIV} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;
`endif

endpackage

// File: rtl/multicycle_alu_shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
// done is high during the cycle whose closing edge writes the final product.
module shift_add_multiplier #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   product,
  output logic             done
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  mcand;
  logic [CW-1:0] cnt;
  logic          run;
  logic [W:0]    sum;

  // Upper half accumulates; lower half holds the not-yet-consumed multiplier bits.
  assign sum  = {1'b0, product[2*W-1:W]} + (product[0] ? {1'b0, mcand} : '0);
  assign done = run && (cnt == CW'(W-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product <= '0;
      mcand   <= '0;
      cnt     <= '0;
      run     <= 1'b0;
    end else if (start) begin
      product <= {{W{1'b0}}, b};
      mcand   <= a;
      cnt     <= '0;
      run     <= 1'b1;
    end else if (run) begin
      product <= {sum, product[W-1:1]};
      cnt     <= cnt + 1'b1;
      if (cnt == CW'(W-1)) run <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// EX-stage ALU with start/busy/done handshake: single-cycle ops plus iterative MULTU.
// Define MULTICYCLE_ALU_DIV_EN to add iterative DIVU (restoring division).
module multicycle_alu
  import alu_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [OP_WIDTH-1:0]   alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic                  zero_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  illegal_o
);

  state_t                  state;
  logic [OP_WIDTH-1:0]     op_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q, res_q;
  logic                    ill_q;
  logic                    mul_start, mul_done;
  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0]   fin_lo, fin_hi;
  logic                    fin_ill;

  // Returns {illegal, result} for the single-cycle operations.
  function automatic logic [DATA_WIDTH:0] exec_op(input logic [OP_WIDTH-1:0] op,
                                                   input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    case (op)
      ALU_ADD: return {1'b0, a + b};
      ALU_SUB: return {1'b0, a - b};
      ALU_OR:  return {1'b0, a | b};
      ALU_LUI: return {1'b0, b[15:0], {(DATA_WIDTH-16){1'b0}}};
      default: return {1'b1, {DATA_WIDTH{1'b0}}};
    endcase
  endfunction

  assign mul_start = (state == ST_IDLE) && start_i && (alu_operation_i == ALU_MULTU);

  shift_add_multiplier #(.W(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_i),
    .b       (b_i),
    .product (product),
    .done    (mul_done)
  );

`ifdef MULTICYCLE_ALU_DIV_EN
  localparam int CNT_W = $clog2(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] quo_q, rem_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH:0]   shifted;
  logic                  fits;

  // b=0 always fits, which naturally yields all-ones quotient and remainder=a.
  assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};
  assign fits    = shifted >= {1'b0, b_q};
`endif

  always_comb begin
    fin_lo  = res_q;
    fin_hi  = '0;
    fin_ill = ill_q;
    if (op_q == ALU_MULTU) begin
      fin_lo  = product[DATA_WIDTH-1:0];
      fin_hi  = product[2*DATA_WIDTH-1:DATA_WIDTH];
      fin_ill = 1'b0;
    end
`ifdef MULTICYCLE_ALU_DIV_EN
    if (op_q == ALU_DIVU) begin
      fin_lo  = quo_q;
      fin_hi  = rem_q;
      fin_ill = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      ill_q     <= 1'b0;
      result_o  <= '0;
      hi_o      <= '0;
      zero_o    <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      illegal_o <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      done_o    <= 1'b0;
      illegal_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            op_q   <= alu_operation_i;
            a_q    <= a_i;
            b_q    <= b_i;
            busy_o <= 1'b1;
            if (alu_operation_i == ALU_MULTU) state <= ST_MUL;
`ifdef MULTICYCLE_ALU_DIV_EN
            else if (alu_operation_i == ALU_DIVU) state <= ST_DIV;
`endif
            else state <= ST_EXEC;
`ifdef MULTICYCLE_ALU_DIV_EN
            quo_q <= a_i;
            rem_q <= '0;
            cnt_q <= '0;
`endif
          end
        end
        ST_EXEC: begin
          {ill_q, res_q} <= exec_op(op_q, a_q, b_q);
          state          <= ST_DONE;
        end
        ST_MUL: begin
          if (mul_done) state <= ST_DONE;
        end
`ifdef MULTICYCLE_ALU_DIV_EN
        ST_DIV: begin
          rem_q <= fits ? (shifted[DATA_WIDTH-1:0] - b_q) : shifted[DATA_WIDTH-1:0];
          quo_q <= {quo_q[DATA_WIDTH-2:0], fits};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_WIDTH-1)) state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          result_o  <= fin_lo;
          hi_o      <= fin_hi;
          zero_o    <= (fin_lo == '0);
          illegal_o <= fin_ill;
          done_o    <= 1'b1;
          busy_o    <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu; DIVU vectors run when
// MULTICYCLE_ALU_DIV_EN is defined, otherwise 4'b0111 is checked as illegal.
module tb_multicycle_alu;

  logic        clk, reset, start_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_i, b_i, result_o, hi_o;
  logic        zero_o, busy_o, done_o, illegal_o;

  int checks = 0;
  int errors = 0;
  int busy_drop = 0;
  int cnt, seen;

  multicycle_alu #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .result_o        (result_o),
    .hi_o            (hi_o),
    .zero_o          (zero_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .illegal_o       (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    alu_operation_i = op;
    a_i = a;
    b_i = b;
  endtask

  // cnt counts cycles since the cycle start_i was first driven.
  task automatic wait_done(inout int c);
    while (!done_o && c < 60) begin
      @(posedge clk); #1;
      c++;
      if (!done_o && !busy_o) busy_drop++;
    end
  endtask

  task automatic check_done(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                            input logic ill);
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    chk({tag, "_result"}, 64'(result_o), 64'(lo));
    chk({tag, "_hi"}, 64'(hi_o), 64'(hi));
    chk({tag, "_zero"}, 64'(zero_o), 64'(lo == 32'd0));
    chk({tag, "_illegal"}, 64'(illegal_o), 64'(ill));
    chk({tag, "_busy_low"}, 64'(busy_o), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] lo,
                        input logic [31:0] hi, input logic ill);
    int c;
    @(posedge clk); #1;
    drive(op, a, b);
    @(posedge clk); #1;
    start_i = 1'b0;
    c = 1;
    chk({tag, "_busy"}, 64'(busy_o), 64'd1);
    wait_done(c);
    chk({tag, "_latency"}, 64'(c), 64'(lat));
    check_done(tag, lo, hi, ill);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b0000, 32'd0, 32'd0);
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_zero", 64'(zero_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_illegal", 64'(illegal_o), 64'd0);
    reset = 1'b0;

    run_op("or", 4'b0010, 32'hF0F0_0000, 32'h0000_0F0F, 3, 32'hF0F0_0F0F, 32'd0, 1'b0);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    drive(4'b0110, 32'd5, 32'd7);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    chk("rstmul_result", 64'(result_o), 64'd0);
    chk("rstmul_hi", 64'(hi_o), 64'd0);
    chk("rstmul_zero", 64'(zero_o), 64'd1);
    chk("rstmul_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) seen++;
    end
    chk("rstmul_no_done", 64'(seen), 64'd0);

    run_op("add_1_1", 4'b0011, 32'd1, 32'd1, 3, 32'd2, 32'd0, 1'b0);
    run_op("add_wrap", 4'b0011, 32'hFFFF_FFFF, 32'd1, 3, 32'd0, 32'd0, 1'b0);
    run_op("sub", 4'b0100, 32'd5, 32'd7, 3, 32'hFFFF_FFFE, 32'd0, 1'b0);
    run_op("lui", 4'b0101, 32'h1111_1111, 32'hABCD_1234, 3, 32'h1234_0000, 32'd0, 1'b0);

    // Start asserted in the DONE-state cycle is ignored, then accepted in IDLE.
    @(posedge clk); #1;
    drive(4'b0011, 32'd2, 32'd3);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    drive(4'b0011, 32'd10, 32'd20);
    chk("held_done_early", 64'(done_o), 64'd0);
    @(posedge clk); #1;
    check_done("held_first", 32'd5, 32'd0, 1'b0);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("held_accept_busy", 64'(busy_o), 64'd1);
    chk("held_accept_done", 64'(done_o), 64'd0);
    cnt = 1;
    wait_done(cnt);
    chk("held_second_latency", 64'(cnt), 64'd3);
    check_done("held_second", 32'd30, 32'd0, 1'b0);

    run_op("illegal", 4'b1001, 32'd5, 32'd6, 3, 32'd0, 32'd0, 1'b1);

    busy_drop = 0;
    run_op("multu_max", 4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0000_0001,
           32'hFFFF_FFFE, 1'b0);
    chk("multu_busy_gap", 64'(busy_drop), 64'd0);

    // Operand, op and start changes while busy must not disturb the multiply.
    @(posedge clk); #1;
    drive(4'b0110, 32'd3, 32'd4);
    @(posedge clk); #1;
    cnt = 1;
    drive(4'b0011, 32'd100, 32'd200);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cnt++;
      start_i = ~start_i;
      a_i = a_i + 32'd1;
    end
    start_i = 1'b0;
    wait_done(cnt);
    chk("hs_latency", 64'(cnt), 64'd34);
    check_done("hs", 32'd12, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hs_hold_result", 64'(result_o), 64'd12);

`ifdef MULTICYCLE_ALU_DIV_EN
    run_op("divu", 4'b0111, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);
    run_op("divu_zero", 4'b0111, 32'd9, 32'd0, 34, 32'hFFFF_FFFF, 32'd9, 1'b0);
`else
    run_op("op0111_illegal", 4'b0111, 32'd100, 32'd7, 3, 32'd0, 32'd0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
